// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter:
// ALU control codes, FSM states and requester ids.
package alu_share_arbiter_pkg;

   localparam logic [3:0] CTRL_AND   = 4'b0000;
   localparam logic [3:0] CTRL_OR    = 4'b0001;
   localparam logic [3:0] CTRL_ADD   = 4'b0010;
   localparam logic [3:0] CTRL_SUB   = 4'b0110;
   localparam logic [3:0] CTRL_PASSB = 4'b0111;
   localparam logic [3:0] CTRL_MOVZ  = 4'b1000;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic ctrl_legal(input logic [3:0] c);
      logic ok;
      ok = 1'b0;
      case (c)
         CTRL_AND, CTRL_OR, CTRL_ADD,
         CTRL_SUB, CTRL_PASSB, CTRL_MOVZ: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 64-bit ALU: AND/OR/ADD/SUB/PassB/MOVZ.
// Unknown control codes yield zero.
module alu_share_arbiter_alu
   import alu_share_arbiter_pkg::*;
#(
   parameter int WIDTH = 64
) (
   output logic [WIDTH-1:0] BusW,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [3:0]       ALUCtrl,
   output logic             Zero
);

   logic [WIDTH-1:0] w_imm;
   logic [5:0]       w_shamt;

   assign w_imm   = {{(WIDTH-16){1'b0}}, BusA[20:5]};
   assign w_shamt = {BusA[22:21], 4'b0000};

   always_comb begin
      BusW = '0;
      case (ALUCtrl)
         CTRL_AND:   BusW = BusA & BusB;
         CTRL_OR:    BusW = BusA | BusB;
         CTRL_ADD:   BusW = BusA + BusB;
         CTRL_SUB:   BusW = BusA - BusB;
         CTRL_PASSB: BusW = BusB;
         CTRL_MOVZ:  BusW = w_imm << w_shamt;
         default:    BusW = '0;
      endcase
   end

   assign Zero = (BusW == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters,
// with a registered result on per-requester response channels.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREQ  = 2
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [3:0]       req_ctrl0,
   input  logic [3:0]       req_ctrl1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_b1,
   output logic [NREQ-1:0]  rsp_valid,
   input  logic [NREQ-1:0]  rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_rr_ptr;
   logic             r_gid;
   logic [3:0]       r_ctrl;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_err;

   logic             w_win_vld;
   logic             w_win_id;
   logic [NREQ-1:0]  w_req_ready;
   logic [NREQ-1:0]  w_rsp_valid;
   logic             w_legal;
   logic [3:0]       w_alu_ctrl;
   logic [WIDTH-1:0] w_alu_out;
   logic             w_alu_zero;

   always_comb begin
      w_win_vld   = 1'b0;
      w_win_id    = r_rr_ptr;
      w_req_ready = '0;
      if (r_state == ST_IDLE) begin
         if (req_valid[r_rr_ptr]) begin
            w_win_vld = 1'b1;
            w_win_id  = r_rr_ptr;
         end else if (req_valid[~r_rr_ptr]) begin
            w_win_vld = 1'b1;
            w_win_id  = ~r_rr_ptr;
         end
         if (w_win_vld) w_req_ready[w_win_id] = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_win_vld) w_state_nxt = ST_EXEC;
         ST_EXEC: w_state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready[r_gid]) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rsp_valid = '0;
      if (r_state == ST_RESP) w_rsp_valid[r_gid] = 1'b1;
   end

   // Illegal codes never reach the ALU; PassB is a harmless stand-in.
   assign w_legal    = ctrl_legal(r_ctrl);
   assign w_alu_ctrl = w_legal ? r_ctrl : CTRL_PASSB;

   alu_share_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
      .BusW    (w_alu_out),
      .BusA    (r_a),
      .BusB    (r_b),
      .ALUCtrl (w_alu_ctrl),
      .Zero    (w_alu_zero)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= REQ0;
         r_gid    <= REQ0;
         r_ctrl   <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_win_vld) begin
            r_gid    <= w_win_id;
            r_rr_ptr <= ~w_win_id;
            r_ctrl   <= (w_win_id == REQ1) ? req_ctrl1 : req_ctrl0;
            r_a      <= (w_win_id == REQ1) ? req_a1 : req_a0;
            r_b      <= (w_win_id == REQ1) ? req_b1 : req_b0;
         end
         if (r_state == ST_EXEC) begin
            r_result <= w_legal ? w_alu_out : '0;
            r_zero   <= w_legal ? w_alu_zero : 1'b1;
            r_err    <= ~w_legal;
         end
      end
   end

   assign req_ready  = w_req_ready;
   assign rsp_valid  = w_rsp_valid;
   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;
   assign rsp_err    = r_err;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an expected-response
// queue checked whenever a response handshake completes.
module tb_alu_share_arbiter;

   localparam logic [3:0] C_AND  = 4'b0000;
   localparam logic [3:0] C_OR   = 4'b0001;
   localparam logic [3:0] C_ADD  = 4'b0010;
   localparam logic [3:0] C_SUB  = 4'b0110;
   localparam logic [3:0] C_PB   = 4'b0111;
   localparam logic [3:0] C_MOVZ = 4'b1000;
   localparam logic [3:0] C_BAD  = 4'b1111;

   typedef struct packed {
      logic        id;
      logic [63:0] res;
      logic        z;
      logic        e;
   } exp_t;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [3:0]  req_ctrl0 = '0;
   logic [3:0]  req_ctrl1 = '0;
   logic [63:0] req_a0 = '0;
   logic [63:0] req_a1 = '0;
   logic [63:0] req_b0 = '0;
   logic [63:0] req_b1 = '0;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready = '0;
   logic [63:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_err;
   logic        busy;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   alu_share_arbiter dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_ctrl0  (req_ctrl0),
      .req_ctrl1  (req_ctrl1),
      .req_a0     (req_a0),
      .req_a1     (req_a1),
      .req_b0     (req_b0),
      .req_b1     (req_b1),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic id, input logic [3:0] c,
                                  input logic [63:0] a,
                                  input logic [63:0] b);
      exp_t r;
      logic [63:0] imm;
      r.id = id;
      r.e  = 1'b0;
      imm  = {48'd0, a[20:5]};
      case (c)
         C_AND:  r.res = a & b;
         C_OR:   r.res = a | b;
         C_ADD:  r.res = a + b;
         C_SUB:  r.res = a - b;
         C_PB:   r.res = b;
         C_MOVZ: r.res = imm << (16 * a[22:21]);
         default: begin
            r.res = '0;
            r.e   = 1'b1;
         end
      endcase
      r.z = (r.res == 64'd0);
      return r;
   endfunction

   // Response monitor: one pop per completed handshake.
   exp_t m_e;
   always @(negedge CLK) begin
      if (!Reset) begin
         for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               if (q.size() == 0) begin
                  chk("unexpected_rsp", 64'(q.size()), 64'd1);
               end else begin
                  m_e = q.pop_front();
                  chk("rsp_id", 64'(i), 64'(m_e.id));
                  chk("rsp_result", rsp_result, m_e.res);
                  chk("rsp_zero", 64'(rsp_zero), 64'(m_e.z));
                  chk("rsp_err", 64'(rsp_err), 64'(m_e.e));
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Reset     = 1'b1;
      req_valid = '0;
      step();
      step();
      Reset = 1'b0;
   endtask

   task automatic set_op(input logic id, input logic [3:0] c,
                         input logic [63:0] a, input logic [63:0] b);
      if (id) begin
         req_ctrl1 = c;
         req_a1    = a;
         req_b1    = b;
      end else begin
         req_ctrl0 = c;
         req_a0    = a;
         req_b0    = b;
      end
   endtask

   task automatic run_op(input logic id, input logic [3:0] c,
                         input logic [63:0] a, input logic [63:0] b);
      int n;
      set_op(id, c, a, b);
      req_valid[id] = 1'b1;
      #1;
      n = 0;
      while (!req_ready[id] && n < 10) begin
         step();
         n++;
      end
      chk("grant_wait", 64'(req_ready[id]), 64'd1);
      q.push_back(model(id, c, a, b));
      step();
      req_valid[id] = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      chk("idle_wait", 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   logic [3:0] codes [7];
   logic       rid;
   logic [3:0] rc;
   logic [63:0] ra, rb;

   initial begin
      codes = '{C_AND, C_OR, C_ADD, C_SUB, C_PB, C_MOVZ, 4'b1011};

      // reset state
      do_reset();
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result", rsp_result, 64'd0);
      chk("rst_zero", 64'(rsp_zero), 64'd0);
      chk("rst_err", 64'(rsp_err), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);

      // single ADD, latency 2
      rsp_ready = 2'b11;
      set_op(1'b0, C_ADD, 64'd5, 64'd7);
      req_valid = 2'b01;
      #1;
      chk("t1_ready", 64'(req_ready), 64'd1);
      q.push_back('{id: 1'b0, res: 64'd12, z: 1'b0, e: 1'b0});
      step();
      req_valid = 2'b00;
      chk("t1_exec_busy", 64'(busy), 64'd1);
      chk("t1_exec_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t1_exec_ready", 64'(req_ready), 64'd0);
      step();
      chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t1_result", rsp_result, 64'd12);
      step();
      chk("t1_done_valid", 64'(rsp_valid), 64'd0);
      chk("t1_done_busy", 64'(busy), 64'd0);

      // simultaneous requests after reset
      do_reset();
      set_op(1'b0, C_SUB, 64'd10, 64'd10);
      set_op(1'b1, C_OR, 64'hF0, 64'h0F);
      req_valid = 2'b11;
      #1;
      chk("t2_ready_first", 64'(req_ready), 64'd1);
      q.push_back('{id: 1'b0, res: 64'd0, z: 1'b1, e: 1'b0});
      q.push_back('{id: 1'b1, res: 64'hFF, z: 1'b0, e: 1'b0});
      step();
      req_valid = 2'b10;
      chk("t2_exec_ready", 64'(req_ready), 64'd0);
      step();
      chk("t2_rsp0_valid", 64'(rsp_valid), 64'd1);
      chk("t2_rsp0_ready", 64'(req_ready), 64'd0);
      chk("t2_rsp0_zero", 64'(rsp_zero), 64'd1);
      step();
      chk("t2_ready_second", 64'(req_ready), 64'd2);
      step();
      req_valid = 2'b00;
      step();
      chk("t2_rsp1_valid", 64'(rsp_valid), 64'd2);
      chk("t2_rsp1_result", rsp_result, 64'hFF);
      step();
      chk("t2_done_busy", 64'(busy), 64'd0);

      // MOVZ with response back-pressure and a pending requester
      rsp_ready = 2'b00;
      set_op(1'b0, C_MOVZ, (64'd2 << 21) | (64'hBEEF << 5), 64'h1234);
      req_valid = 2'b01;
      #1;
      chk("t3_ready", 64'(req_ready), 64'd1);
      q.push_back('{id: 1'b0, res: 64'h0000_BEEF_0000_0000,
                    z: 1'b0, e: 1'b0});
      step();
      set_op(1'b1, C_AND, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F);
      req_valid = 2'b10;
      q.push_back('{id: 1'b1, res: 64'h0F000F000F000F00,
                    z: 1'b0, e: 1'b0});
      step();
      for (int k = 0; k < 4; k++) begin
         chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
         chk("t3_hold_result", rsp_result, 64'h0000_BEEF_0000_0000);
         chk("t3_hold_ready", 64'(req_ready), 64'd0);
         step();
      end
      rsp_ready = 2'b11;
      step();
      chk("t3_pending_ready", 64'(req_ready), 64'd2);
      step();
      req_valid = 2'b00;
      for (int k = 0; k < 20 && busy; k++) step();
      chk("t3_done_busy", 64'(busy), 64'd0);

      // illegal code, then a legal one clears err
      run_op(1'b0, C_BAD, 64'hDEAD, 64'hBEEF);
      chk("t4_err", 64'(rsp_err), 64'd1);
      chk("t4_result", rsp_result, 64'd0);
      run_op(1'b0, C_PB, 64'hDEAD, 64'h1234);
      chk("t4_err_clear", 64'(rsp_err), 64'd0);

      // reset while in EXEC discards the operation
      set_op(1'b0, C_ADD, 64'd1, 64'd2);
      req_valid = 2'b01;
      step();
      Reset     = 1'b1;
      req_valid = 2'b00;
      step();
      Reset = 1'b0;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_result", rsp_result, 64'd0);
      for (int k = 0; k < 4; k++) begin
         chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
         step();
      end
      req_valid = 2'b11;
      #1;
      chk("t5_rr_reset", 64'(req_ready), 64'd1);
      req_valid = 2'b00;
      run_op(1'b1, C_ADD, 64'd100, 64'd23);
      chk("t5_r1_result", rsp_result, 64'd123);

      // mixed operations from both requesters
      for (int k = 0; k < 8; k++) begin
         rid = 1'($urandom_range(0, 1));
         rc  = codes[$urandom_range(0, 6)];
         ra  = {$urandom, $urandom};
         rb  = {$urandom, $urandom};
         run_op(rid, rc, ra, rb);
      end
      run_op(1'b0, C_SUB, 64'd0, 64'd1);

      step();
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
